// File: rtl/wide_dec_fmt.sv
// Streams an unsigned binary value as ASCII decimal, most significant digit first.
// Conversion is serial double-dabble (one bit per cycle); emission is one character
// per valid/ready handshake.
// Ports:
//   clk, rst              - clock, async active-high reset
//   in_valid/in_ready     - input handshake, in_data (WIDTH bits)
//   out_valid/out_ready   - output handshake, out_char (ASCII),
//                           out_last (final char), out_trunc (value overflowed DIGITS)
//   busy                  - conversion or emission in progress
module wide_dec_fmt #(
   parameter int WIDTH  = 64,
   parameter int DIGITS = 20,
   parameter int PAD_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_last,
   output logic             out_trunc,
   output logic             busy
);

   localparam int BW    = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH);
   localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      EMIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [BW-1:0]      bcd_q, bcd_d;
   logic               trunc_q, trunc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;

   logic [BW-1:0]      adj;
   logic [BW-1:0]      nbcd;
   logic [PTR_W-1:0]   msd;
   logic [3:0]         dig;
   logic               zero_up;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         bcd_q   <= '0;
         trunc_q <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
         trunc_q <= trunc_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   // One double-dabble step: correct digits >= 5, then shift in the next bit.
   // The top bit of adj is the carry out of the most significant digit.
   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      nbcd = {adj[BW-2:0], sr_q[WIDTH-1]};
      msd  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (nbcd[4*i +: 4] != 4'd0) begin
            msd = PTR_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bcd_d   = bcd_q;
      trunc_d = trunc_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = in_data;
               bcd_d   = '0;
               trunc_d = 1'b0;
               cnt_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            sr_d    = {sr_q[WIDTH-2:0], 1'b0};
            bcd_d   = nbcd;
            trunc_d = trunc_q | adj[BW-1];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = EMIT;
               ptr_d   = (PAD_EN != 0) ? PTR_W'(DIGITS - 1) : msd;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (ptr_q == '0) begin
                  state_d = IDLE;
               end else begin
                  ptr_d = ptr_q - PTR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Character decode from registered state only; zero_up flags that every
   // digit at or above the pointer is zero (a leading-zero position).
   always_comb begin
      dig     = 4'd0;
      zero_up = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (PTR_W'(i) == ptr_q) begin
            dig = bcd_q[4*i +: 4];
         end
         if (PTR_W'(i) >= ptr_q && bcd_q[4*i +: 4] != 4'd0) begin
            zero_up = 1'b0;
         end
      end
      out_valid = (state_q == EMIT);
      in_ready  = (state_q == IDLE);
      busy      = (state_q != IDLE);
      out_last  = out_valid && (ptr_q == '0);
      out_trunc = out_valid && trunc_q;
      out_char  = 8'h20;
      if (out_valid) begin
         if ((PAD_EN != 0) && (ptr_q != '0) && zero_up) begin
            out_char = 8'h20;
         end else begin
            out_char = 8'h30 + {4'h0, dig};
         end
      end
   end

endmodule

// File: tb/tb_wide_dec_fmt.sv
// Self-checking bench for wide_dec_fmt: three parameterisations driven with
// directed and random values, checked against an arithmetic decimal model.
module tb_wide_dec_fmt;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid[3];
   logic [63:0] in_data[3];
   logic        out_ready[3];
   logic        in_ready[3];
   logic        out_valid[3];
   logic [7:0]  out_char[3];
   logic        out_last[3];
   logic        out_trunc[3];
   logic        busy[3];

   int width_of[3]  = '{64, 64, 16};
   int digits_of[3] = '{20, 20, 3};
   int pad_of[3]    = '{1, 0, 1};

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   wide_dec_fmt #(.WIDTH(64), .DIGITS(20), .PAD_EN(1)) u0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_char(out_char[0]),
      .out_last(out_last[0]), .out_trunc(out_trunc[0]), .busy(busy[0])
   );

   wide_dec_fmt #(.WIDTH(64), .DIGITS(20), .PAD_EN(0)) u1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_char(out_char[1]),
      .out_last(out_last[1]), .out_trunc(out_trunc[1]), .busy(busy[1])
   );

   wide_dec_fmt #(.WIDTH(16), .DIGITS(3), .PAD_EN(1)) u2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2][15:0]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_char(out_char[2]),
      .out_last(out_last[2]), .out_trunc(out_trunc[2]), .busy(busy[2])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: digits by repeated division, then apply padding rules.
   task automatic model(input int k, input logic [63:0] v,
                        output logic [7:0] q[$], output logic tr);
      int d[20];
      longint unsigned t;
      int nd;
      int top;
      bit lead;
      t  = v;
      nd = digits_of[k];
      for (int i = 0; i < 20; i++) d[i] = 0;
      for (int i = 0; i < nd; i++) begin
         d[i] = int'(t % 10);
         t    = t / 10;
      end
      tr  = (t != 0);
      q   = {};
      top = nd - 1;
      if (pad_of[k] == 0) begin
         top = 0;
         for (int i = 0; i < nd; i++) if (d[i] != 0) top = i;
      end
      lead = 1'b1;
      for (int i = top; i >= 0; i--) begin
         if (d[i] != 0 || i == 0) lead = 1'b0;
         if (lead) q.push_back(8'h20);
         else q.push_back(8'(8'h30 + d[i]));
      end
   endtask

   task automatic run(input int k, input logic [63:0] v, input bit bp);
      logic [7:0] exp_q[$];
      logic       tr;
      int         n;
      int         idx;
      int         guard;
      bit         r;
      bit         stalled;
      logic [7:0] held;
      model(k, v, exp_q, tr);
      chk($sformatf("k%0d idle_in_ready", k), 64'(in_ready[k]), 64'd1);
      in_valid[k] = 1'b1;
      in_data[k]  = v;
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      in_data[k]  = {$urandom, $urandom};
      chk($sformatf("k%0d busy_after_accept", k), 64'(busy[k]), 64'd1);
      chk($sformatf("k%0d in_ready_conv", k), 64'(in_ready[k]), 64'd0);
      n = 0;
      while (!out_valid[k] && n < 5000) begin
         in_valid[k] = 1'($urandom % 2);
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("k%0d latency v=%0d", k, v), 64'(n), 64'(width_of[k]));
      if (!out_valid[k]) begin
         in_valid[k] = 1'b0;
         return;
      end
      idx     = 0;
      guard   = 0;
      stalled = 1'b0;
      held    = 8'h00;
      while (idx < exp_q.size() && guard < 2000) begin
         chk($sformatf("k%0d v=%0d out_valid[%0d]", k, v, idx), 64'(out_valid[k]), 64'd1);
         chk($sformatf("k%0d v=%0d char[%0d]", k, v, idx), 64'(out_char[k]), 64'(exp_q[idx]));
         chk($sformatf("k%0d v=%0d last[%0d]", k, v, idx), 64'(out_last[k]),
             64'(idx == exp_q.size() - 1));
         chk($sformatf("k%0d v=%0d trunc[%0d]", k, v, idx), 64'(out_trunc[k]), 64'(tr));
         chk($sformatf("k%0d v=%0d in_ready_emit", k, v), 64'(in_ready[k]), 64'd0);
         if (stalled) begin
            chk($sformatf("k%0d v=%0d stall_hold", k, v), 64'(out_char[k]), 64'(held));
         end
         r            = bp ? 1'($urandom % 2) : 1'b1;
         out_ready[k] = r;
         in_valid[k]  = 1'($urandom % 2);
         held         = out_char[k];
         @(posedge clk); #1;
         if (r) idx++;
         stalled = !r;
         guard++;
      end
      out_ready[k] = 1'b0;
      in_valid[k]  = 1'b0;
      chk($sformatf("k%0d emit_done", k), 64'(idx), 64'(exp_q.size()));
      chk($sformatf("k%0d out_valid_after", k), 64'(out_valid[k]), 64'd0);
      chk($sformatf("k%0d in_ready_after", k), 64'(in_ready[k]), 64'd1);
      chk($sformatf("k%0d busy_after", k), 64'(busy[k]), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s k%0d in_ready", tag, k), 64'(in_ready[k]), 64'd1);
         chk($sformatf("%s k%0d out_valid", tag, k), 64'(out_valid[k]), 64'd0);
         chk($sformatf("%s k%0d out_char", tag, k), 64'(out_char[k]), 64'h20);
         chk($sformatf("%s k%0d out_last", tag, k), 64'(out_last[k]), 64'd0);
         chk($sformatf("%s k%0d out_trunc", tag, k), 64'(out_trunc[k]), 64'd0);
         chk($sformatf("%s k%0d busy", tag, k), 64'(busy[k]), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] v;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         out_ready[k] = 1'b0;
      end
      #12;
      check_reset_state("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run(0, 64'd0, 1'b0);
      run(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      run(1, 64'd1234, 1'b0);
      run(1, 64'd0, 1'b0);
      run(0, 64'd9876543210, 1'b1);

      // Reset in the middle of a conversion abandons the value.
      in_valid[0] = 1'b1;
      in_data[0]  = 64'd777777777;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (29) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_reset_state("midconv_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst out_valid c%0d", i), 64'(out_valid[0]), 64'd0);
      end
      chk("post_rst in_ready", 64'(in_ready[0]), 64'd1);
      run(0, 64'd42, 1'b0);

      run(2, 64'd1000, 1'b0);
      run(2, 64'd999, 1'b1);
      run(2, 64'd0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 3; k++) begin
            v = {$urandom, $urandom};
            v = v >> ($urandom % 64);
            if (k == 2) v = v & 64'hFFFF;
            run(k, v, 1'b1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wide_dec_fmt.md
WIDE_DEC_FMT -- requirements
Module: wide_dec_fmt

Interface
REQ-001 SHALL have parameter WIDTH, default 64: input value width in bits, legal range 4..4096.
REQ-002 SHALL have parameter DIGITS, default 20: number of decimal digit positions held.
REQ-003 SHALL have parameter PAD_EN, default 1: 1 = pad leading zeros with spaces to DIGITS characters; 0 = suppress them.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the ports are named clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  block accepts in_data.
REQ-009 in_data  input  WIDTH  unsigned binary value to format.
REQ-010 out_valid  output  1  out_char valid.
REQ-011 out_ready  input  1  consumer accepts out_char.
REQ-012 out_char  output  8  ASCII character: space 8'h20 or digit 8'h30..8'h39.
REQ-013 out_last  output  1  marks the final character of the current value.
REQ-014 out_trunc  output  1  value exceeded DIGITS decimal digits; valid while out_valid.
REQ-015 busy  output  1  high in CONV or EMIT.

Function
REQ-016 SHALL implement states IDLE, CONV and EMIT.
REQ-017 in_ready SHALL equal (state==IDLE); there is no overlap between values.
REQ-018 IDLE: on in_valid&&in_ready, SHALL capture in_data into the shift register, clear all BCD digits, clear the trunc flag, zero the bit counter and enter CONV.
REQ-019 CONV: each cycle, SHALL add 3 to every BCD digit >=5 and then shift {BCD,shift register} left by one bit.
REQ-020 CONV: a 1 shifted out of the top BCD digit SHALL set the sticky trunc flag.
REQ-021 CONV SHALL last exactly WIDTH cycles and then enter EMIT; the first out_valid is visible WIDTH cycles after the accepting edge.
REQ-022 Entry to EMIT, PAD_EN=1: the digit pointer SHALL be set to DIGITS-1.
REQ-023 Entry to EMIT, PAD_EN=0: the digit pointer SHALL be set to the index of the most-significant nonzero digit, or 0 if all digits are zero.
REQ-024 EMIT: out_valid=1; out_char = 8'h30+digit[ptr].
REQ-025 EMIT exception: out_char SHALL be 8'h20 when PAD_EN=1, ptr>0 and all digits at ptr and above are zero.
REQ-026 Digit 0 SHALL always be emitted as a numeral.
REQ-027 out_last SHALL equal (ptr==0).
REQ-028 out_valid&&out_ready with ptr>0 SHALL decrement ptr.
REQ-029 out_valid&&out_ready with ptr==0 SHALL return the block to IDLE.
REQ-030 While out_valid&&!out_ready, out_char, out_last and out_trunc SHALL hold stable.
REQ-031 out_trunc SHALL be asserted on every character of a truncated value; the low DIGITS digits are emitted.
REQ-032 in_valid in CONV or EMIT SHALL be ignored with no state change.
REQ-033 Outputs SHALL be registered or decoded from state only, with no combinational path from in_* to out_*.

Reset
REQ-034 rst SHALL immediately force IDLE with in_ready=1, out_valid=0, out_char=8'h20, out_last=0, out_trunc=0, busy=0, BCD=0 and counters=0.
REQ-035 rst asserted during CONV or EMIT SHALL abandon the value silently; no partial character is presented after release.
REQ-036 The first accepted value after reset release SHALL convert correctly.

Verification
REQ-037 Default params, in_data=0, out_ready=1 -> 19x 8'h20 then "0"; out_last on the 20th character only; out_trunc=0.
REQ-038 in_data=64'hFFFF_FFFF_FFFF_FFFF -> "18446744073709551615" with no spaces; first out_valid 64 cycles after acceptance.
REQ-039 PAD_EN=0, in_data=1234 -> exactly "1","2","3","4" with out_last on "4"; in_ready returns high the cycle after.
REQ-040 Backpressure: out_ready random 50% on in_data=9876543210 -> same 20-character sequence; out_char stable on stalls; in_ready=0 until the final handshake.
REQ-041 rst pulsed at CONV cycle 30, then in_data=42 -> out_valid stays 0 during and after the pulse until the new value; output "...42" correct.
REQ-042 DIGITS=3, PAD_EN=1, in_data=1000 -> "  0" with out_trunc=1 on all three characters.
